// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the Monte-Carlo pricing path streaming logic.
//   feeder_state_t : FSM states of mc_path_feeder
//   clog2          : ceil(log2(value)), never less than 1, for port and counter widths
//   MC_WIDTH/MC_PATHS/MC_DAYS : default geometry shared with MC_CORE and its bench
package mc_pkg;

  localparam int MC_WIDTH = 12;
  localparam int MC_PATHS = 256;
  localparam int MC_DAYS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT,
    DONE
  } feeder_state_t;

  // A width of at least one bit keeps single-entry counters legal.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/mc_path_addr_gen.sv
// mc_path_addr_gen: day / path-index / pass counters and path RAM address.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          start of a run: latch dir_in / n_pass_in, load first day
//   dir_in        day order for the run (0 upward, 1 downward)
//   n_pass_in     passes per day for the run (0 behaves as 1)
//   issue         a RAM read is issued this cycle
//   next_pass     replay the current day (pass + 1)
//   next_day      step to the next day in the latched direction
//   mem_addr      day * PATHS + idx
//   day, pass     current day and pass index
//   idx_last      idx points at the last path of the day
//   rd_done       every path of the current pass has been read
//   pass_last     current pass is the final pass of the day
//   day_last      current day is the final day in the latched direction
module mc_path_addr_gen
  import mc_pkg::*;
#(
  parameter int PATHS = MC_PATHS,
  parameter int DAYS  = MC_DAYS,
  parameter int AW    = $clog2(PATHS * DAYS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     dir_in,
  input  logic [1:0]               n_pass_in,
  input  logic                     issue,
  input  logic                     next_pass,
  input  logic                     next_day,
  output logic [AW-1:0]            mem_addr,
  output logic [clog2(DAYS)-1:0]   day,
  output logic [1:0]               pass,
  output logic                     idx_last,
  output logic                     rd_done,
  output logic                     pass_last,
  output logic                     day_last
);

  localparam int IW = clog2(PATHS);
  localparam int DW = clog2(DAYS);
  localparam logic [IW-1:0] IDX_LAST = IW'(PATHS - 1);
  localparam logic [DW-1:0] DAY_LAST = DW'(DAYS - 1);

  logic [IW-1:0] idx_q;
  logic [DW-1:0] day_q;
  logic [1:0]    pass_q;
  logic [1:0]    n_pass_q;
  logic          dir_q;
  logic          rd_done_q;
  logic [2:0]    n_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      day_q     <= '0;
      pass_q    <= '0;
      n_pass_q  <= '0;
      dir_q     <= 1'b0;
      rd_done_q <= 1'b0;
    end else if (load) begin
      day_q     <= dir_in ? DAY_LAST : '0;
      pass_q    <= '0;
      idx_q     <= '0;
      rd_done_q <= 1'b0;
      n_pass_q  <= n_pass_in;
      dir_q     <= dir_in;
    end else if (next_pass) begin
      pass_q    <= pass_q + 2'd1;
      idx_q     <= '0;
      rd_done_q <= 1'b0;
    end else if (next_day) begin
      day_q     <= dir_q ? (day_q - 1'b1) : (day_q + 1'b1);
      pass_q    <= '0;
      idx_q     <= '0;
      rd_done_q <= 1'b0;
    end else if (issue) begin
      // idx parks on the last path; rd_done blocks further reads of this pass.
      if (idx_q == IDX_LAST) begin
        rd_done_q <= 1'b1;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign n_eff     = (n_pass_q == 2'd0) ? 3'd1 : {1'b0, n_pass_q};
  assign pass_last = (({1'b0, pass_q} + 3'd1) >= n_eff);
  assign day_last  = dir_q ? (day_q == '0) : (day_q == DAY_LAST);
  assign idx_last  = (idx_q == IDX_LAST);
  assign rd_done   = rd_done_q;
  assign day       = day_q;
  assign pass      = pass_q;
  assign mem_addr  = AW'(day_q) * AW'(PATHS) + AW'(idx_q);

endmodule

// File: rtl/mc_path_feeder.sv
// mc_path_feeder: streams simulated price paths from a synchronous path RAM to
// MC_CORE one day at a time, replaying a day on each resend until the latched
// pass count is reached, then advancing to the next day.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            begin a run when idle (latches dir and n_pass)
//   dir              0: day 0 upward, 1: day DAYS-1 downward
//   n_pass           passes per day (0 behaves as 1)
//   resend           core has consumed the current pass
//   ready            core accepts path this cycle
//   mem_en/mem_addr  RAM read request
//   mem_rdata        RAM data, one cycle after mem_en, held otherwise
//   path/path_valid  sample to the core
//   day, pass        current day and pass index
//   busy             run in progress
//   done             one-cycle pulse at the end of the run
//   err              sticky: resend seen while streaming; cleared by start
module mc_path_feeder
  import mc_pkg::*;
#(
  parameter int WIDTH = MC_WIDTH,
  parameter int PATHS = MC_PATHS,
  parameter int DAYS  = MC_DAYS,
  parameter int AW    = $clog2(PATHS * DAYS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   dir,
  input  logic [1:0]             n_pass,
  input  logic                   resend,
  input  logic                   ready,
  output logic                   mem_en,
  output logic [AW-1:0]          mem_addr,
  input  logic [WIDTH-1:0]       mem_rdata,
  output logic [WIDTH-1:0]       path,
  output logic                   path_valid,
  output logic [clog2(DAYS)-1:0] day,
  output logic [1:0]             pass,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  feeder_state_t state_q, state_d;

  logic load, next_pass, next_day;
  logic issue, xfer;
  logic idx_last, rd_done, pass_last, day_last;
  logic vld_p1, last_p1, err_q;

  mc_path_addr_gen #(
    .PATHS (PATHS),
    .DAYS  (DAYS),
    .AW    (AW)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .dir_in    (dir),
    .n_pass_in (n_pass),
    .issue     (issue),
    .next_pass (next_pass),
    .next_day  (next_day),
    .mem_addr  (mem_addr),
    .day       (day),
    .pass      (pass),
    .idx_last  (idx_last),
    .rd_done   (rd_done),
    .pass_last (pass_last),
    .day_last  (day_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    next_pass = 1'b0;
    next_day  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        busy = 1'b1;
        if (xfer && last_p1) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (resend) begin
          if (!pass_last) begin
            next_pass = 1'b1;
            state_d   = STREAM;
          end else if (day_last) begin
            state_d = DONE;
          end else begin
            next_day = 1'b1;
            state_d  = STREAM;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read request: refill the output stage whenever it is empty or draining.
  assign issue  = (state_q == STREAM) && !rd_done && (!vld_p1 || ready);
  assign xfer   = vld_p1 && ready;
  assign mem_en = issue;

  // Stage p1: RAM output register; data is held by the RAM, only valid/last tracked here.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (issue) begin
      vld_p1 <= 1'b1;
    end else if (xfer) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      last_p1 <= idx_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (load) begin
      err_q <= 1'b0;
    end else if ((state_q == STREAM) && resend) begin
      err_q <= 1'b1;
    end
  end

  assign path       = mem_rdata;
  assign path_valid = vld_p1;
  assign err        = err_q;

endmodule

// File: tb/tb_mc_path_feeder.sv
module tb_mc_path_feeder;

  localparam int WIDTH = 12;
  localparam int PATHS = 4;
  localparam int DAYS  = 2;
  localparam int AW    = 3;
  localparam int DW    = 1;

  logic             clk = 1'b0;
  logic             rst, start, dir, resend, ready;
  logic [1:0]       n_pass;
  logic             mem_en;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_rdata = '0;
  logic [WIDTH-1:0] path;
  logic             path_valid;
  logic [DW-1:0]    day;
  logic [1:0]       pass;
  logic             busy, done, err;

  always #5 clk = ~clk;

  mc_path_feeder #(
    .WIDTH (WIDTH),
    .PATHS (PATHS),
    .DAYS  (DAYS),
    .AW    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dir        (dir),
    .n_pass     (n_pass),
    .resend     (resend),
    .ready      (ready),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .path       (path),
    .path_valid (path_valid),
    .day        (day),
    .pass       (pass),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Synchronous path RAM: one-cycle read latency, output held when not enabled.
  logic [WIDTH-1:0] ram [PATHS*DAYS];
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int addr;
    int day;
    int pass;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    bit       dir;
    bit [1:0] np;
    int       rmode;       // 0: ready=1, 1: random, 2: pattern 1,0,0,1
    int       rdelay;      // cycles in WAIT before resend
    bit       inj;         // stray resend + start mid-stream
    int       exp_passes;
    int       exp_maxpass;
    int       exp_err;
  } case_t;
  case_t tbl[7];

  task automatic run_case(input bit d, input logic [1:0] np, input int rmode, input int rdelay,
                          input bit inj, output int xfers, output int maxpass, output int err_end);
    int npe, cnt, w, cyc;
    bit final_rs, injected, err_next, chk_err, prev_stall, first;
    logic [WIDTH-1:0] prev_path;
    beat_t b;
    exp_q.delete();
    npe = (np == 2'd0) ? 1 : int'(np);
    for (int k = 0; k < DAYS; k++) begin
      int dd;
      dd = d ? (DAYS - 1 - k) : k;
      for (int p = 0; p < npe; p++)
        for (int i = 0; i < PATHS; i++)
          exp_q.push_back('{dd * PATHS + i, dd, p});
    end
    xfers = 0; maxpass = 0; cnt = 0; w = 0;
    final_rs = 0; injected = 0; err_next = 0; prev_stall = 0; first = 1;
    prev_path = '0;
    @(negedge clk);
    dir = d; n_pass = np; start = 1'b1;
    @(negedge clk);
    for (cyc = 0; cyc < 400; cyc++) begin
      start = 1'b0;
      resend = 1'b0;
      chk_err = err_next;
      err_next = 0;
      if (final_rs) begin
        #1;
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        break;
      end
      if (w > 0) begin
        w--;
        if (w == 0) begin
          resend = 1'b1;
          if (exp_q.size() == 0) final_rs = 1;
        end
      end
      if (inj && !injected && cnt == 1 && xfers == 1) begin
        resend = 1'b1;
        start = 1'b1;
        dir = !d;
        n_pass = 2'd3;
        injected = 1;
        err_next = 1;
      end
      case (rmode)
        0: ready = 1'b1;
        1: ready = 1'($urandom_range(0, 1));
        default: ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      #1;
      if (first) begin
        check("err_after_start", err, 0);
        check("busy_after_start", busy, 1);
        check("first_mem_en", mem_en, 1);
        check("first_addr", mem_addr, exp_q[0].addr);
        first = 0;
      end
      if (chk_err) check("err_after_stray_resend", err, 1);
      check("no_early_done", done, 0);
      if (prev_stall) begin
        check("stall_hold_valid", path_valid, 1);
        check("stall_hold_path", path, prev_path);
      end
      if (path_valid && !ready) check("stall_no_read", mem_en, 0);
      if (path_valid && ready) begin
        if (exp_q.size() == 0) begin
          check("transfer_overrun", xfers, -1);
        end else begin
          b = exp_q.pop_front();
          check("path_data", path, ram[b.addr]);
          check("day", day, b.day);
          check("pass", pass, b.pass);
          xfers++;
          if (int'(pass) > maxpass) maxpass = int'(pass);
          cnt++;
          if (cnt == PATHS) begin
            cnt = 0;
            w = rdelay;
          end
        end
      end
      prev_stall = path_valid && !ready;
      prev_path = path;
      @(negedge clk);
    end
    if (cyc >= 400) check("run_timeout", cyc, 0);
    err_end = int'(err);
    start = 1'b0;
    resend = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_path_valid"}, path_valid, 0);
    check({tag, "_day"}, day, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    int xf, mp, ee, npe;
    bit rd;
    logic [1:0] rnp;
    rst = 1'b1; start = 1'b0; dir = 1'b0; n_pass = 2'd0; resend = 1'b0; ready = 1'b0;
    for (int i = 0; i < PATHS * DAYS; i++) ram[i] = WIDTH'(i * 309 + 679);

    tbl[0] = '{1'b0, 2'd2, 0, 3, 1'b0, 2, 1, 0};
    tbl[1] = '{1'b1, 2'd2, 0, 3, 1'b0, 2, 1, 0};
    tbl[2] = '{1'b0, 2'd0, 1, 1, 1'b0, 1, 0, 0};
    tbl[3] = '{1'b1, 2'd3, 1, 2, 1'b0, 3, 2, 0};
    tbl[4] = '{1'b0, 2'd1, 2, 4, 1'b0, 1, 0, 0};
    tbl[5] = '{1'b1, 2'd2, 2, 1, 1'b1, 2, 1, 1};
    tbl[6] = '{1'b0, 2'd3, 1, 2, 1'b0, 3, 2, 0};

    repeat (3) @(negedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      run_case(tbl[t].dir, tbl[t].np, tbl[t].rmode, tbl[t].rdelay, tbl[t].inj, xf, mp, ee);
      check($sformatf("case%0d_transfers", t), xf, DAYS * PATHS * tbl[t].exp_passes);
      check($sformatf("case%0d_max_pass", t), mp, tbl[t].exp_maxpass);
      check($sformatf("case%0d_err", t), ee, tbl[t].exp_err);
      check($sformatf("case%0d_leftover", t), exp_q.size(), 0);
    end

    for (int r = 0; r < 6; r++) begin
      rd = 1'($urandom_range(0, 1));
      rnp = 2'($urandom_range(0, 3));
      npe = (rnp == 2'd0) ? 1 : int'(rnp);
      run_case(rd, rnp, 1, int'($urandom_range(1, 4)), 1'b0, xf, mp, ee);
      check($sformatf("rand%0d_transfers", r), xf, DAYS * PATHS * npe);
      check($sformatf("rand%0d_max_pass", r), mp, npe - 1);
      check($sformatf("rand%0d_err", r), ee, 0);
    end

    // Reset mid-stream with a read in flight and err set.
    @(negedge clk);
    dir = 1'b0; n_pass = 2'd1; start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0; resend = 1'b1;
    #1;
    check("t1_mem_en", mem_en, 1);
    check("t1_mem_addr", mem_addr, 0);
    check("t1_path_valid", path_valid, 0);
    @(negedge clk);
    resend = 1'b0;
    #1;
    check("t2_path_valid", path_valid, 1);
    check("t2_path", path, ram[0]);
    check("t2_mem_addr", mem_addr, 1);
    check("t2_err", err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_state("midrst");

    run_case(1'b0, 2'd2, 0, 3, 1'b0, xf, mp, ee);
    check("restart_transfers", xf, DAYS * PATHS * 2);
    check("restart_err", ee, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
